// File: rtl/fsm_seq_pkg.sv
// Shared types and constants for the serial pattern generator.
// State encoding, default pattern and counter sizing helper.
package fsm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        PAR     = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    localparam logic [6:0] DEF_PATTERN = 7'b1110010;

    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-in serial-out shift register, MSB first.
// Load has priority over shift; synchronous active-high clear.
module seq_piso #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_din,
    output logic         o_msb
);

    logic [W-1:0] r_sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_din;
        end else if (i_shift) begin
            r_sr <= {r_sr[W-2:0], 1'b0};
        end
    end

    assign o_msb = r_sr[W-1];

endmodule

// File: rtl/fsm_seq_gen.sv
// Serial pattern generator: shifts a latched pattern out MSB first, rpt+1 frames.
// Optional per-frame even-parity bit when FSM_SEQ_GEN_PARITY_EN is defined.
module fsm_seq_gen
    import fsm_seq_pkg::*;
#(
    parameter int               PAT_W   = 7,
    parameter logic [PAT_W-1:0] DEF_PAT = DEF_PATTERN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             use_def,
    input  logic [PAT_W-1:0] pattern,
    input  logic [3:0]       rpt,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam int            CW       = cnt_w(PAT_W);
    localparam logic [CW-1:0] LAST_BIT = CW'(PAT_W - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_rep_cnt;
    logic [CW-1:0]    r_bit_cnt;
    logic [PAT_W-1:0] r_pat;
    logic [PAT_W-1:0] w_sel_pat;
    logic [PAT_W-1:0] w_load_val;
    logic             w_accept;
    logic             w_reload;
    logic             w_shift;
    logic             w_last_bit;
    logic             w_done;
    logic             w_valid;
    logic             w_out;
    logic             w_msb;
`ifdef FSM_SEQ_GEN_PARITY_EN
    logic             r_par;
`endif

    assign w_sel_pat  = use_def ? DEF_PAT : pattern;
    assign w_last_bit = (r_bit_cnt == '0);
    assign w_load_val = w_accept ? w_sel_pat : r_pat;

    always_comb begin
        w_next_state = IDLE;
        w_accept     = 1'b0;
        w_reload     = 1'b0;
        w_shift      = 1'b0;
        w_done       = 1'b0;
        w_valid      = 1'b0;
        w_out        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = SEND;
                end
            end
            SEND: begin
                w_valid      = 1'b1;
                w_out        = w_msb;
                w_shift      = 1'b1;
                w_next_state = SEND;
                if (w_last_bit) begin
`ifdef FSM_SEQ_GEN_PARITY_EN
                    w_next_state = PAR;
`else
                    w_done       = (r_rep_cnt == '0);
                    w_reload     = !w_done;
                    w_next_state = w_done ? IDLE : SEND;
`endif
                end
            end
`ifdef FSM_SEQ_GEN_PARITY_EN
            PAR: begin
                w_valid      = 1'b1;
                w_out        = r_par;
                w_done       = (r_rep_cnt == '0);
                w_reload     = !w_done;
                w_next_state = w_done ? IDLE : SEND;
            end
`endif
            default: w_next_state = IDLE;
        endcase
    end

    // Counters and latched pattern; illegal encodings fall back to IDLE via w_next_state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_rep_cnt <= '0;
            r_bit_cnt <= '0;
            r_pat     <= '0;
`ifdef FSM_SEQ_GEN_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_pat     <= w_sel_pat;
                r_rep_cnt <= rpt;
                r_bit_cnt <= LAST_BIT;
`ifdef FSM_SEQ_GEN_PARITY_EN
                r_par     <= ^w_sel_pat;
`endif
            end else if (w_reload) begin
                r_rep_cnt <= r_rep_cnt - 4'd1;
                r_bit_cnt <= LAST_BIT;
            end else if (r_state == SEND && !w_last_bit) begin
                r_bit_cnt <= r_bit_cnt - 1'b1;
            end
        end
    end

    seq_piso #(.W(PAT_W)) u_piso (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_accept | w_reload),
        .i_shift (w_shift),
        .i_din   (w_load_val),
        .o_msb   (w_msb)
    );

    assign out   = w_out;
    assign valid = w_valid;
    assign busy  = w_valid;
    assign done  = w_done;
    assign state = r_state;

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Directed self-checking bench for fsm_seq_gen.
// Parity scenario runs only when FSM_SEQ_GEN_PARITY_EN is defined.
module tb_fsm_seq_gen;

    logic       clk;
    logic       reset;
    logic       start;
    logic       use_def;
    logic [6:0] pattern;
    logic [3:0] rpt;
    logic       out;
    logic       valid;
    logic       busy;
    logic       done;
    logic [1:0] state;

    int n_tests;
    int n_fail;

    fsm_seq_gen #(.PAT_W(7)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .use_def (use_def),
        .pattern (pattern),
        .rpt     (rpt),
        .out     (out),
        .valid   (valid),
        .busy    (busy),
        .done    (done),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        n_tests++;
        if (state !== 2'd0 || out !== 1'b0 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d out=%b valid=%b busy=%b done=%b, expected all 0",
                     state, out, valid, busy, done);
        end
        reset = 1'b0;
        tick;
        n_tests++;
        if (state !== 2'd0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_hold: state=%0d valid=%b, expected 0 0", state, valid);
        end
    endtask

    task automatic test_default_frame;
        logic [6:0] exp_pat;
        logic       exp_done;
        exp_pat = 7'b1110010;
        use_def = 1'b1;
        pattern = 7'b0000000;
        rpt     = 4'd0;
        start   = 1'b1;
        tick;
        start   = 1'b0;
        for (int i = 0; i < 7; i++) begin
            exp_done = (i == 6);
            n_tests++;
            if (out !== exp_pat[6-i] || valid !== 1'b1 || busy !== 1'b1 || done !== exp_done) begin
                n_fail++;
                $display("FAIL default_bit%0d: out=%b valid=%b busy=%b done=%b, expected out=%b valid=1 busy=1 done=%b",
                         i, out, valid, busy, done, exp_pat[6-i], exp_done);
            end
            tick;
        end
        n_tests++;
        if (busy !== 1'b0 || valid !== 1'b0 || out !== 1'b0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL default_after: busy=%b valid=%b out=%b state=%0d, expected 0 0 0 0",
                     busy, valid, out, state);
        end
    endtask

    task automatic test_repeat;
        logic [6:0] exp_pat;
        logic       exp_done;
        exp_pat = 7'b1010011;
        use_def = 1'b0;
        pattern = exp_pat;
        rpt     = 4'd2;
        start   = 1'b1;
        tick;
        start   = 1'b0;
        pattern = 7'b0101100;
        rpt     = 4'd9;
        use_def = 1'b1;
        for (int i = 0; i < 21; i++) begin
            exp_done = (i == 20);
            n_tests++;
            if (out !== exp_pat[6-(i%7)] || valid !== 1'b1 || done !== exp_done) begin
                n_fail++;
                $display("FAIL repeat_bit%0d: out=%b valid=%b done=%b, expected out=%b valid=1 done=%b",
                         i, out, valid, done, exp_pat[6-(i%7)], exp_done);
            end
            tick;
        end
        n_tests++;
        if (valid !== 1'b0 || busy !== 1'b0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL repeat_after: valid=%b busy=%b state=%0d, expected 0 0 0", valid, busy, state);
        end
    endtask

    task automatic test_start_while_busy;
        logic [6:0] exp_pat;
        logic [6:0] new_pat;
        exp_pat = 7'b1100101;
        new_pat = 7'b0101011;
        use_def = 1'b0;
        pattern = exp_pat;
        rpt     = 4'd0;
        start   = 1'b1;
        tick;
        start   = 1'b0;
        for (int i = 0; i < 7; i++) begin
            n_tests++;
            if (out !== exp_pat[6-i] || valid !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_ignore_bit%0d: out=%b valid=%b, expected out=%b valid=1",
                         i, out, valid, exp_pat[6-i]);
            end
            if (i == 2) begin
                start   = 1'b1;
                pattern = 7'b0011010;
                rpt     = 4'd3;
            end else begin
                start   = 1'b0;
            end
            tick;
        end
        n_tests++;
        if (state !== 2'd0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ignore_after: state=%0d valid=%b, expected 0 0", state, valid);
        end
        pattern = new_pat;
        rpt     = 4'd0;
        start   = 1'b1;
        tick;
        start   = 1'b0;
        for (int i = 0; i < 7; i++) begin
            n_tests++;
            if (out !== new_pat[6-i] || valid !== 1'b1) begin
                n_fail++;
                $display("FAIL restart_bit%0d: out=%b valid=%b, expected out=%b valid=1",
                         i, out, valid, new_pat[6-i]);
            end
            tick;
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [6:0] exp_pat;
        exp_pat = 7'b1110010;
        use_def = 1'b1;
        rpt     = 4'd1;
        start   = 1'b1;
        tick;
        start   = 1'b0;
        for (int i = 0; i < 3; i++) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        n_tests++;
        if (valid !== 1'b0 || out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL midreset: valid=%b out=%b busy=%b done=%b state=%0d, expected all 0",
                     valid, out, busy, done, state);
        end
        rpt   = 4'd0;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            n_tests++;
            if (out !== exp_pat[6-i] || valid !== 1'b1 || done !== (i == 6)) begin
                n_fail++;
                $display("FAIL midreset_frame_bit%0d: out=%b valid=%b done=%b, expected out=%b valid=1",
                         i, out, valid, done, exp_pat[6-i]);
            end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0] exp_pat;
        exp_pat = 7'b1110010;
        use_def = 1'b1;
        rpt     = 4'd0;
        start   = 1'b1;
        tick;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 7; i++) begin
                n_tests++;
                if (out !== exp_pat[6-i] || valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_f%0d_bit%0d: out=%b valid=%b, expected out=%b valid=1",
                             f, i, out, valid, exp_pat[6-i]);
                end
                tick;
            end
            n_tests++;
            if (valid !== 1'b0 || busy !== 1'b0 || state !== 2'd0) begin
                n_fail++;
                $display("FAIL b2b_gap%0d: valid=%b busy=%b state=%0d, expected 0 0 0",
                         f, valid, busy, state);
            end
            if (f == 1) start = 1'b0;
            tick;
        end
        n_tests++;
        if (valid !== 1'b0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL b2b_stop: valid=%b state=%0d, expected 0 0", valid, state);
        end
    endtask

`ifdef FSM_SEQ_GEN_PARITY_EN
    task automatic test_parity;
        logic [6:0] exp_pat;
        logic       exp_bit;
        exp_pat = 7'b1110000;
        use_def = 1'b0;
        pattern = exp_pat;
        rpt     = 4'd1;
        start   = 1'b1;
        tick;
        start   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_bit = ((i % 8) == 7) ? 1'b1 : exp_pat[6-(i%8)];
            n_tests++;
            if (out !== exp_bit || valid !== 1'b1 || done !== (i == 15)) begin
                n_fail++;
                $display("FAIL parity_bit%0d: out=%b valid=%b done=%b, expected out=%b valid=1",
                         i, out, valid, done, exp_bit);
            end
            tick;
        end
        n_tests++;
        if (valid !== 1'b0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL parity_after: valid=%b state=%0d, expected 0 0", valid, state);
        end
        use_def = 1'b1;
        rpt     = 4'd0;
        start   = 1'b1;
        tick;
        start   = 1'b0;
        for (int i = 0; i < 7; i++) tick;
        n_tests++;
        if (out !== 1'b0 || valid !== 1'b1 || done !== 1'b1 || state !== 2'd2) begin
            n_fail++;
            $display("FAIL parity_default: out=%b valid=%b done=%b state=%0d, expected 0 1 1 2",
                     out, valid, done, state);
        end
        tick;
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        use_def = 1'b0;
        pattern = '0;
        rpt     = '0;
        test_reset;
        test_default_frame;
        test_repeat;
        test_start_while_busy;
        tick;
        test_reset_mid_frame;
        tick;
        test_back_to_back;
`ifdef FSM_SEQ_GEN_PARITY_EN
        test_parity;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
